// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and register index type for the register file
//
// Contents:
//   DEFAULT_DATA_WIDTH  default register/data port width
//   DEFAULT_ADDR_WIDTH  default address width (2**ADDR_WIDTH registers)
//   regIdx_t            register index type at the default address width

package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] regIdx_t;

endpackage

// File: rtl/regfile_decoder.sv
// rtl/regfile_decoder.sv - address to one-hot decode for write and lock strobes
//
// Ports:
//   en      in   1                 strobe enable; output is all zeros when low
//   addr    in   ADDR_WIDTH        register address
//   oneHot  out  2**ADDR_WIDTH     one bit per register, set for the addressed one

module regfile_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                        en,
  input  logic [ADDR_WIDTH-1:0]       addr,
  output logic [(1<<ADDR_WIDTH)-1:0]  oneHot
);

  always_comb begin
    oneHot = '0;
    if (en) begin
      oneHot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - two-write, two-read register file with per-register busy locks
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
//
// Ports:
//   clock                       in   1           sole clock, rising edge
//   ctrl_reset                  in   1           synchronous active-high reset
//   ctrl_writeEn0/1             in   1           write port enables
//   ctrl_writeReg0/1            in   ADDR_WIDTH  write port addresses
//   data_writeReg0/1            in   DATA_WIDTH  write port data
//   ctrl_readRegA/B             in   ADDR_WIDTH  read addresses
//   data_readRegA/B             out  DATA_WIDTH  read data (combinational)
//   ctrl_lockEn                 in   1           mark ctrl_lockReg as awaiting a result
//   ctrl_lockReg                in   ADDR_WIDTH  register to lock
//   busy_readRegA/B             out  1           busy bit of the addressed register

module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic                   ctrl_writeEn0,
  input  logic [ADDR_WIDTH-1:0]  ctrl_writeReg0,
  input  logic [DATA_WIDTH-1:0]  data_writeReg0,
  input  logic                   ctrl_writeEn1,
  input  logic [ADDR_WIDTH-1:0]  ctrl_writeReg1,
  input  logic [DATA_WIDTH-1:0]  data_writeReg1,
  input  logic [ADDR_WIDTH-1:0]  ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0]  ctrl_readRegB,
  output logic [DATA_WIDTH-1:0]  data_readRegA,
  output logic [DATA_WIDTH-1:0]  data_readRegB,
  input  logic                   ctrl_lockEn,
  input  logic [ADDR_WIDTH-1:0]  ctrl_lockReg,
  output logic                   busy_readRegA,
  output logic                   busy_readRegB
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;

  logic [NUM_REGS-1:0]   writeHot0;
  logic [NUM_REGS-1:0]   writeHot1;
  logic [NUM_REGS-1:0]   lockHot;

  regfile_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_decWrite0 (
    .en     (ctrl_writeEn0),
    .addr   (ctrl_writeReg0),
    .oneHot (writeHot0)
  );

  regfile_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_decWrite1 (
    .en     (ctrl_writeEn1),
    .addr   (ctrl_writeReg1),
    .oneHot (writeHot1)
  );

  regfile_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_decLock (
    .en     (ctrl_lockEn),
    .addr   (ctrl_lockReg),
    .oneHot (lockHot)
  );

  // Register 0 is left untouched after reset when hardwired, so it holds zero.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (!(ZERO_REG != 0 && i == 0)) begin
          // Port 1 is checked first so it wins a same-address collision.
          if (writeHot1[i]) begin
            regs[i] <= data_writeReg1;
          end else if (writeHot0[i]) begin
            regs[i] <= data_writeReg0;
          end
          // A lock arriving with the write leaves the register busy.
          if (lockHot[i]) begin
            busy[i] <= 1'b1;
          end else if (writeHot0[i] || writeHot1[i]) begin
            busy[i] <= 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] readData(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] value;
    value = regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (ctrl_writeEn1 && ctrl_writeReg1 == addr) begin
      value = data_writeReg1;
    end else if (ctrl_writeEn0 && ctrl_writeReg0 == addr) begin
      value = data_writeReg0;
    end
`endif
    if (ZERO_REG != 0 && addr == '0) begin
      value = '0;
    end
    return value;
  endfunction

  function automatic logic readBusy(input logic [ADDR_WIDTH-1:0] addr);
    logic value;
    value = busy[addr];
`ifdef REGFILE_BYPASS_EN
    // Forwarded data is the result being waited for, so it is not busy.
    if ((ctrl_writeEn1 && ctrl_writeReg1 == addr) ||
        (ctrl_writeEn0 && ctrl_writeReg0 == addr)) begin
      value = 1'b0;
    end
`endif
    if (ZERO_REG != 0 && addr == '0) begin
      value = 1'b0;
    end
    return value;
  endfunction

  always_comb begin
    data_readRegA = readData(ctrl_readRegA);
    data_readRegB = readData(ctrl_readRegB);
    busy_readRegA = readBusy(ctrl_readRegA);
    busy_readRegB = readBusy(ctrl_readRegB);
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param with a behavioural array model

module tb_regfile_param;
  import regfile_pkg::*;

  localparam int NR = 32;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        ctrl_writeEn0 = 1'b0;
  regIdx_t     ctrl_writeReg0 = '0;
  logic [31:0] data_writeReg0 = '0;
  logic        ctrl_writeEn1 = 1'b0;
  regIdx_t     ctrl_writeReg1 = '0;
  logic [31:0] data_writeReg1 = '0;
  regIdx_t     ctrl_readRegA = '0;
  regIdx_t     ctrl_readRegB = '0;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        ctrl_lockEn = 1'b0;
  regIdx_t     ctrl_lockReg = '0;
  logic        busy_readRegA;
  logic        busy_readRegB;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [NR];
  logic        bsy [NR];

  regfile_param dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .ctrl_writeEn0  (ctrl_writeEn0),
    .ctrl_writeReg0 (ctrl_writeReg0),
    .data_writeReg0 (data_writeReg0),
    .ctrl_writeEn1  (ctrl_writeEn1),
    .ctrl_writeReg1 (ctrl_writeReg1),
    .data_writeReg1 (data_writeReg1),
    .ctrl_readRegA  (ctrl_readRegA),
    .ctrl_readRegB  (ctrl_readRegB),
    .data_readRegA  (data_readRegA),
    .data_readRegB  (data_readRegB),
    .ctrl_lockEn    (ctrl_lockEn),
    .ctrl_lockReg   (ctrl_lockReg),
    .busy_readRegA  (busy_readRegA),
    .busy_readRegB  (busy_readRegB)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Value a reader should see right now: register 0 is always zero, and in the
  // forwarding build a pending write shows through (port 1 preferred).
  function automatic logic [31:0] expData(input regIdx_t a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (ctrl_writeEn1 && ctrl_writeReg1 == a) return data_writeReg1;
    if (ctrl_writeEn0 && ctrl_writeReg0 == a) return data_writeReg0;
`endif
    return mem[a];
  endfunction

  function automatic logic [31:0] expBusy(input regIdx_t a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if ((ctrl_writeEn1 && ctrl_writeReg1 == a) || (ctrl_writeEn0 && ctrl_writeReg0 == a)) return 32'h0;
`endif
    return {31'h0, bsy[a]};
  endfunction

  task automatic checkReads(input string tag);
    check({tag, "_dataA"}, data_readRegA, expData(ctrl_readRegA));
    check({tag, "_dataB"}, data_readRegB, expData(ctrl_readRegB));
    check({tag, "_busyA"}, {31'h0, busy_readRegA}, expBusy(ctrl_readRegA));
    check({tag, "_busyB"}, {31'h0, busy_readRegB}, expBusy(ctrl_readRegB));
  endtask

  // One rising edge; the model applies the inputs held across that edge.
  task automatic tick();
    @(posedge clock);
    if (ctrl_reset) begin
      for (int i = 0; i < NR; i++) begin
        mem[i] = 32'h0;
        bsy[i] = 1'b0;
      end
    end else begin
      if (ctrl_writeEn0) begin mem[ctrl_writeReg0] = data_writeReg0; bsy[ctrl_writeReg0] = 1'b0; end
      if (ctrl_writeEn1) begin mem[ctrl_writeReg1] = data_writeReg1; bsy[ctrl_writeReg1] = 1'b0; end
      if (ctrl_lockEn) bsy[ctrl_lockReg] = 1'b1;
      mem[0] = 32'h0;
      bsy[0] = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    ctrl_reset = 1'b0;
    ctrl_writeEn0 = 1'b0;
    ctrl_writeEn1 = 1'b0;
    ctrl_lockEn = 1'b0;
  endtask

  function automatic regIdx_t pickAddr();
    return ($urandom_range(0, 1) == 1) ? regIdx_t'($urandom_range(0, 7)) : regIdx_t'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int i = 0; i < NR; i++) begin
      mem[i] = 32'h0;
      bsy[i] = 1'b0;
    end

    // Reset for two cycles, then every address on both ports reads zero.
    @(negedge clock);
    ctrl_reset = 1'b1;
    tick();
    tick();
    idle();
    for (int i = 0; i < NR; i++) begin
      ctrl_readRegA = regIdx_t'(i);
      ctrl_readRegB = regIdx_t'(NR - 1 - i);
      #1;
      check("rst_dataA", data_readRegA, 32'h0);
      check("rst_dataB", data_readRegB, 32'h0);
      check("rst_busyA", {31'h0, busy_readRegA}, 32'h0);
      check("rst_busyB", {31'h0, busy_readRegB}, 32'h0);
    end

    // Fill 1..31 through port 0, then read back; register 0 stays zero.
    for (int i = 1; i < NR; i++) begin
      ctrl_writeEn0 = 1'b1;
      ctrl_writeReg0 = regIdx_t'(i);
      data_writeReg0 = 32'h0000DEAD;
      tick();
    end
    idle();
    for (int i = 1; i < NR; i++) begin
      ctrl_readRegA = regIdx_t'(i);
      ctrl_readRegB = regIdx_t'(i);
      #1;
      check("dead_A", data_readRegA, 32'h0000DEAD);
      check("dead_B", data_readRegB, 32'h0000DEAD);
    end
    ctrl_writeEn0 = 1'b1;
    ctrl_writeReg0 = '0;
    data_writeReg0 = 32'h0000DEAD;
    tick();
    idle();
    ctrl_readRegA = '0;
    #1;
    check("zero_reg", data_readRegA, 32'h0);

    // Same-address collision goes to port 1; different addresses both land.
    ctrl_writeEn0 = 1'b1; ctrl_writeReg0 = 5'd10; data_writeReg0 = 32'h11111111;
    ctrl_writeEn1 = 1'b1; ctrl_writeReg1 = 5'd10; data_writeReg1 = 32'h22222222;
    tick();
    idle();
    ctrl_readRegA = 5'd10;
    #1;
    check("collide", data_readRegA, 32'h22222222);
    ctrl_writeEn0 = 1'b1; ctrl_writeReg0 = 5'd3; data_writeReg0 = 32'h0000AAAA;
    ctrl_writeEn1 = 1'b1; ctrl_writeReg1 = 5'd4; data_writeReg1 = 32'h0000BBBB;
    tick();
    idle();
    ctrl_readRegA = 5'd3;
    ctrl_readRegB = 5'd4;
    #1;
    check("dual_p0", data_readRegA, 32'h0000AAAA);
    check("dual_p1", data_readRegB, 32'h0000BBBB);

    // Lock, clear by write, then lock and write together.
    ctrl_readRegA = 5'd7;
    ctrl_lockEn = 1'b1; ctrl_lockReg = 5'd7;
    #1;
    check("lock_pre", {31'h0, busy_readRegA}, 32'h0);
    tick();
    idle();
    check("lock_set", {31'h0, busy_readRegA}, 32'h1);
    ctrl_writeEn0 = 1'b1; ctrl_writeReg0 = 5'd7; data_writeReg0 = 32'h5;
    tick();
    idle();
    check("lock_clr_busy", {31'h0, busy_readRegA}, 32'h0);
    check("lock_clr_data", data_readRegA, 32'h5);
    ctrl_writeEn1 = 1'b1; ctrl_writeReg1 = 5'd7; data_writeReg1 = 32'h9;
    ctrl_lockEn = 1'b1; ctrl_lockReg = 5'd7;
    tick();
    idle();
    check("lockwr_data", data_readRegA, 32'h9);
    check("lockwr_busy", {31'h0, busy_readRegA}, 32'h1);
    ctrl_lockEn = 1'b1; ctrl_lockReg = '0;
    ctrl_readRegA = '0;
    tick();
    idle();
    check("lock_zero", {31'h0, busy_readRegA}, 32'h0);

    // Same-cycle read of a register being written.
    ctrl_readRegA = 5'd12;
    ctrl_writeEn0 = 1'b1; ctrl_writeReg0 = 5'd12; data_writeReg0 = 32'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same", data_readRegA, 32'h1234);
`else
    check("bypass_same", data_readRegA, 32'h0000DEAD);
`endif
    tick();
    idle();
    check("bypass_next", data_readRegA, 32'h1234);

    // Disabled write leaves the register alone.
    ctrl_writeEn0 = 1'b1; ctrl_writeReg0 = 5'd3; data_writeReg0 = 32'h1;
    tick();
    ctrl_writeEn0 = 1'b0; data_writeReg0 = 32'h0000AAAA;
    tick();
    ctrl_readRegA = 5'd3;
    #1;
    check("we_low", data_readRegA, 32'h1);

    // Random traffic against the array model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      ctrl_reset     = ($urandom_range(0, 29) == 0);
      ctrl_writeEn0  = $urandom_range(0, 1) == 1;
      ctrl_writeReg0 = pickAddr();
      data_writeReg0 = $urandom;
      ctrl_writeEn1  = $urandom_range(0, 1) == 1;
      ctrl_writeReg1 = pickAddr();
      data_writeReg1 = $urandom;
      ctrl_lockEn    = $urandom_range(0, 2) == 0;
      ctrl_lockReg   = pickAddr();
      ctrl_readRegA  = pickAddr();
      ctrl_readRegB  = pickAddr();
      #1;
      checkReads("rnd_pre");
      tick();
      checkReads("rnd_post");
    end
    idle();

    // Put some state in, then reset while writes and a lock are active.
    ctrl_writeEn0 = 1'b1; ctrl_writeReg0 = 5'd5; data_writeReg0 = 32'hCAFE;
    ctrl_lockEn = 1'b1; ctrl_lockReg = 5'd9;
    tick();
    ctrl_reset = 1'b1;
    ctrl_writeEn0 = 1'b1; ctrl_writeReg0 = 5'd6; data_writeReg0 = 32'hBEEF;
    ctrl_writeEn1 = 1'b1; ctrl_writeReg1 = 5'd5; data_writeReg1 = 32'hF00D;
    ctrl_lockEn = 1'b1; ctrl_lockReg = 5'd8;
    tick();
    idle();
    for (int i = 0; i < NR; i++) begin
      ctrl_readRegA = regIdx_t'(i);
      ctrl_readRegB = regIdx_t'(i);
      #1;
      check("midrst_data", data_readRegA, 32'h0);
      check("midrst_busy", {31'h0, busy_readRegB}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the width of each register and each data port.
REQ-002 Parameter ADDR_WIDTH, default 5, sets address width; register count is 2**ADDR_WIDTH.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 ctrl_reset  in  1  synchronous, active-high reset.
REQ-006 ctrl_writeEn0  in  1  write port 0 enable.
REQ-007 ctrl_writeReg0  in  ADDR_WIDTH  write port 0 address.
REQ-008 data_writeReg0  in  DATA_WIDTH  write port 0 data.
REQ-009 ctrl_writeEn1 / ctrl_writeReg1 / data_writeReg1  in  1 / ADDR_WIDTH / DATA_WIDTH  write port 1, same meaning as port 0.
REQ-010 ctrl_readRegA, ctrl_readRegB  in  ADDR_WIDTH  read addresses.
REQ-011 data_readRegA, data_readRegB  out  DATA_WIDTH  read data.
REQ-012 ctrl_lockEn  in  1  marks a register as awaiting a result.
REQ-013 ctrl_lockReg  in  ADDR_WIDTH  register to lock.
REQ-014 busy_readRegA, busy_readRegB  out  1  lock status of addressed register.

Function
REQ-015 Reads SHALL be combinational from stored state; zero-cycle latency from address change.
REQ-016 An enabled write SHALL update the addressed register on the next rising clock edge.
REQ-017 Both ports writing the same address in one cycle: port 1 data SHALL win.
REQ-018 Both ports writing different addresses SHALL both complete in the same cycle.
REQ-019 With ZERO_REG=1, writes to register 0 SHALL be discarded, reads SHALL return 0, lock SHALL be ignored and busy SHALL read 0.
REQ-020 ctrl_lockEn SHALL set the busy bit of ctrl_lockReg on the next rising edge.
REQ-021 An enabled write from either port SHALL clear the busy bit of its address on the same edge it stores data.
REQ-022 Lock and write to the same address in one cycle: data SHALL be stored and busy SHALL end set (lock wins).
REQ-023 busy_readRegA/B SHALL reflect the stored busy bit of the addressed register combinationally.
REQ-024 Out-of-range behaviour SHALL NOT exist; every address value maps to a register.

Reset
REQ-025 ctrl_reset high at a rising edge SHALL clear all registers to 0 and all busy bits to 0.
REQ-026 Reset SHALL take priority over any simultaneous write or lock.
REQ-027 During and after reset, data_readRegA/B and busy_readRegA/B SHALL read 0 for every address until written or locked.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-029 With REGFILE_BYPASS_EN defined, a read address matching an enabled write in the same cycle SHALL return that write data (port 1 over port 0) and busy SHALL read 0 for that address, except register 0 with ZERO_REG=1.
REQ-030 Without REGFILE_BYPASS_EN, reads SHALL return stored state only; new data is visible the cycle after the write edge.

Structure
REQ-031 Package regfile_pkg SHALL hold default DATA_WIDTH/ADDR_WIDTH constants and the register index type.
REQ-032 Sub-module regfile_decoder SHALL provide the ADDR_WIDTH-to-one-hot write/lock decode, instantiated once per write port and once for lock.
REQ-033 Storage and busy bits SHALL be flip-flop arrays inside regfile_param; no memory macros.

Verification
REQ-034 Reset 2 cycles, then read all 32 addresses on both ports -> all data 0, all busy 0.
REQ-035 Write 0x0000DEAD to registers 1..31 via port 0, read back on A and B -> 0x0000DEAD each; write 0x0000DEAD to reg 0 -> reads 0.
REQ-036 Same cycle port 0 writes reg 10 = 0x11111111, port 1 writes reg 10 = 0x22222222 -> reg 10 reads 0x22222222; separately port 0 reg 3 = 0xAAAA, port 1 reg 4 = 0xBBBB -> both stored.
REQ-037 Lock reg 7 -> busy 1 next cycle; write reg 7 = 0x5 -> busy 0, data 0x5; lock and write reg 7 same cycle -> data stored, busy 1.
REQ-038 Write reg 12 = 0x1234 with read A on 12 same cycle -> 0x1234 with REGFILE_BYPASS_EN, old value without; next cycle 0x1234 in both builds.
REQ-039 Write en low with reg 3 = 0xAAAA -> reg 3 unchanged; assert reset mid-sequence with writes active -> all registers and busy 0.
